keypad_time_entry: RTL

Parametrised keypad time-setting block: it collects up to four two-digit BCD fields (hours, minutes, seconds, and one extra 00–59 field) from a one-hot decimal keypad, with `#` committing each field. Each field is range-checked on commit. It drops into the manual-setting path, feeding the clock/alarm time registers with an atomically committed time plus a live edit view for the display. It adds range validation, an inactivity timeout, abort-on-disable and optional backspace.

---
 rtl/keypad_time_entry.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_time_entry.sv
// keypad_time_entry
// Collects up to four two-digit BCD fields from a one-hot decimal keypad.
// '#' commits the current field after a range check. Field 0 is hours, capped
// at HOUR_MAX. The remaining fields are 00-59. The last accepted field
// atomically updates time_out.
// A session is aborted when en drops or after TIMEOUT_CYCLES idle cycles.
// Optional feature: define KEYPAD_BACKSPACE_EN to make '*' a backspace key.
module keypad_time_entry #(
    parameter int          NUM_FIELDS     = 3,
    parameter int          HOUR_MAX       = 23,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [9:0]              keypad,
    input  logic                    sharp,
    input  logic                    star,
    output logic [8*NUM_FIELDS-1:0] time_out,
    output logic [8*NUM_FIELDS-1:0] edit_out,
    output logic [1:0]              field_idx,
    output logic                    busy,
    output logic                    completeSetting,
    output logic                    entry_error,
    output logic                    timeout
);

    localparam int          W          = 8 * NUM_FIELDS;
    localparam logic [1:0]  LAST_IDX   = 2'(NUM_FIELDS - 1);
    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]  HOUR_LIMIT = 7'(HOUR_MAX);
    localparam logic [6:0]  MIN_LIMIT  = 7'd59;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   fld_q [NUM_FIELDS];
    logic [7:0]   fld_d [NUM_FIELDS];
    logic [1:0]   idx_q, idx_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [31:0]  timer_q, timer_d;
    logic [W-1:0] time_d;
    logic         complete_d, error_d, timeout_d;
    logic         en_prev_q, key_prev_q, sharp_prev_q, star_prev_q;

    logic         en_rise, key_ev, sharp_ev, star_ev, key_single;
    logic [3:0]   digit;
    logic [7:0]   cur_fld;
    logic [6:0]   cur_val, cur_lim;

    // Rising-edge events against the registered previous samples
    assign en_rise    = en & ~en_prev_q;
    assign key_ev     = (|keypad) & ~key_prev_q;
    assign sharp_ev   = sharp & ~sharp_prev_q;
    assign star_ev    = star & ~star_prev_q;
    // Only meaningful together with key_ev, which already implies keypad != 0
    assign key_single = (keypad & (keypad - 10'd1)) == 10'd0;

    assign cur_fld = fld_q[idx_q];
    assign cur_val = 7'(cur_fld[7:4]) * 7'd10 + 7'(cur_fld[3:0]);
    assign cur_lim = (idx_q == 2'd0) ? HOUR_LIMIT : MIN_LIMIT;

`ifndef KEYPAD_BACKSPACE_EN
    // '*' has no function in this build; its edge flag is kept for uniformity
    logic unused_star;
    assign unused_star = star_ev;
`endif

    // Encode the one-hot keypad into a binary digit
    always_comb begin
        digit = 4'd0;
        for (int d = 0; d < 10; d++) begin
            if (keypad[d]) digit = 4'(d);
        end
    end

    // Field packing: field 0 sits in the most significant byte
    for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_pack
        assign edit_out[8*(NUM_FIELDS-1-g) +: 8] = fld_q[g];
    end

    assign field_idx = idx_q;
    assign busy      = (state_q != S_IDLE);

    // Next-state and next-output logic; sharp > star > digit within a cycle
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d    = state_q;
        fld_d      = fld_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        time_d     = time_out;
        complete_d = 1'b0;
        error_d    = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_rise) begin
                    state_d = S_ENTRY;
                    fld_d   = '{default: '0};
                    idx_d   = 2'd0;
                    cnt_d   = 2'd0;
                    timer_d = 32'd0;
                end
            end

            S_ENTRY: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (sharp_ev) begin
                    timer_d = 32'd0;
                    if (cur_val > cur_lim) begin
                        error_d      = 1'b1;
                        fld_d[idx_q] = 8'h00;
                        cnt_d        = 2'd0;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        // The next field starts empty so count 0 always shows 00
                        idx_d                = idx_q + 2'd1;
                        cnt_d                = 2'd0;
                        fld_d[idx_q + 2'd1]  = 8'h00;
                    end
`ifdef KEYPAD_BACKSPACE_EN
                end else if (star_ev) begin
                    // A '*' press counts as activity even when it has nothing to erase
                    timer_d = 32'd0;
                    if (cnt_q != 2'd0) begin
                        fld_d[idx_q] = {4'd0, cur_fld[7:4]};
                        cnt_d        = cnt_q - 2'd1;
                    end else if (idx_q != 2'd0) begin
                        idx_d = idx_q - 2'd1;
                        cnt_d = 2'd2;
                    end
`endif
                end else if (key_ev) begin
                    // Multi-key presses are dropped but still count as activity
                    timer_d = 32'd0;
                    if (key_single) begin
                        fld_d[idx_q] = {cur_fld[3:0], digit};
                        cnt_d        = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            S_DONE: begin
                time_d     = edit_out;
                complete_d = 1'b1;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State, edit fields, committed time, pulses and edge flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            // NOTE: the field array drives outputs directly, so all entries are reset.
            fld_q           <= '{default: '0};
            idx_q           <= 2'd0;
            cnt_q           <= 2'd0;
            timer_q         <= 32'd0;
            time_out        <= '0;
            completeSetting <= 1'b0;
            entry_error     <= 1'b0;
            timeout         <= 1'b0;
            en_prev_q       <= 1'b0;
            key_prev_q      <= 1'b0;
            sharp_prev_q    <= 1'b0;
            star_prev_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q         <= state_d;
            fld_q           <= fld_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            timer_q         <= timer_d;
            time_out        <= time_d;
            completeSetting <= complete_d;
            entry_error     <= error_d;
            timeout         <= timeout_d;
            en_prev_q       <= en;
            key_prev_q      <= |keypad;
            sharp_prev_q    <= sharp;
            star_prev_q     <= star;
        end
    end

endmodule
